alarm_ctrl: RTL and testbench

- Alarm controller fed directly by the timer2 time-of-day outputs (sec/min/hour, binary).
- Holds a user-programmed alarm time and asserts a ring output when the time matches.
- Supports snooze (re-arm N minutes later, limited count), stop, and auto-timeout of ringing.
- Sits between timer2 and the buzzer/LED driver.

---
 rtl/alarm_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller driven by the timer2 time-of-day outputs (binary sec/min/hour).
// Latency: alarm_o rises on the clock edge after the cycle where the match first appears; all outputs registered.
// Backpressure: none; strobes (set/snooze/stop) are single-cycle and never stalled.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   sec_i, min_i, hour_i      current time of day from timer2
//   enable_i                  alarm master enable (level)
//   set_i, alarm_hour_i/min_i load alarm time (strobe + value)
//   snooze_i, stop_i          user strobes, honoured only while ringing
//   alarm_o                   ring request
//   armed_o                   armed or snoozing
//   snooze_cnt_o              snoozes used in the current alarm event
//   set_err_o                 one-cycle pulse on out-of-range set value
module alarm_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  input  logic [5:0] hour_i,
  input  logic       enable_i,
  input  logic       set_i,
  input  logic [5:0] alarm_hour_i,
  input  logic [5:0] alarm_min_i,
  input  logic       snooze_i,
  input  logic       stop_i,
  output logic       alarm_o,
  output logic       armed_o,
  output logic [2:0] snooze_cnt_o,
  output logic       set_err_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  state_t     state_q;
  logic [5:0] al_h_q, al_m_q;
  logic [5:0] tgt_h_q, tgt_m_q;
  logic [5:0] sec_q;
  logic       match_q;
  logic [5:0] ring_cnt_q;
  logic [2:0] snooze_cnt_q;
  logic       alarm_q, armed_q, set_err_q;

  logic       tick, match, trigger;
  logic       set_in_range, set_acc;
  logic [5:0] al_h_d, al_m_d;
  logic [6:0] snz_min_sum;
  logic [5:0] hour_inc;
  logic [5:0] snz_h_d, snz_m_d;
  logic [5:0] ring_cnt_d;
  logic       snooze_exhausted;

  always_comb begin
    tick    = (sec_i != sec_q);
    match   = (hour_i == tgt_h_q) && (min_i == tgt_m_q) && (sec_i == 6'd0);
    // Edge-detect so a time held at the target cannot retrigger after stop.
    trigger = match && !match_q;

    set_in_range = (alarm_hour_i <= 6'd23) && (alarm_min_i <= 6'd59);
    set_acc      = set_i && set_in_range && (state_q != S_RINGING);

    // Alarm time as it will be after this cycle; used wherever the target
    // is reloaded so a same-cycle set is not overwritten by the old value.
    al_h_d = set_acc ? alarm_hour_i : al_h_q;
    al_m_d = set_acc ? alarm_min_i  : al_m_q;

    // Snooze target = current hh:mm + SNOOZE_MIN with minute/hour wrap.
    snz_min_sum = {1'b0, min_i} + 7'(SNOOZE_MIN);
    hour_inc    = hour_i + 6'd1;
    if (snz_min_sum >= 7'd60) begin
      snz_m_d = 6'(snz_min_sum - 7'd60);
      snz_h_d = (hour_inc == 6'd24) ? 6'd0 : hour_inc;
    end else begin
      snz_m_d = snz_min_sum[5:0];
      snz_h_d = hour_i;
    end

    ring_cnt_d       = ring_cnt_q + 6'd1;
    snooze_exhausted = (snooze_cnt_q >= 3'(MAX_SNOOZE));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      al_h_q       <= 6'd0;
      al_m_q       <= 6'd0;
      tgt_h_q      <= 6'd0;
      tgt_m_q      <= 6'd0;
      sec_q        <= 6'd0;
      match_q      <= 1'b0;
      ring_cnt_q   <= 6'd0;
      snooze_cnt_q <= 3'd0;
      alarm_q      <= 1'b0;
      armed_q      <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      sec_q     <= sec_i;
      match_q   <= match;
      set_err_q <= 1'b0;

      // Alarm programming; ringing ignores set entirely (no error pulse).
      if (set_i && (state_q != S_RINGING)) begin
        if (set_in_range) begin
          al_h_q       <= alarm_hour_i;
          al_m_q       <= alarm_min_i;
          tgt_h_q      <= alarm_hour_i;
          tgt_m_q      <= alarm_min_i;
          snooze_cnt_q <= 3'd0;
        end else begin
          set_err_q <= 1'b1;
        end
      end

      if (!enable_i) begin
        state_q      <= S_IDLE;
        alarm_q      <= 1'b0;
        armed_q      <= 1'b0;
        snooze_cnt_q <= 3'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_ARMED;
            armed_q <= 1'b1;
            tgt_h_q <= al_h_d;
            tgt_m_q <= al_m_d;
          end
          S_ARMED, S_SNOOZE: begin
            if (trigger) begin
              state_q    <= S_RINGING;
              alarm_q    <= 1'b1;
              armed_q    <= 1'b0;
              ring_cnt_q <= 6'd0;
            end else if (set_acc) begin
              state_q <= S_ARMED;
            end
          end
          S_RINGING: begin
            if (stop_i || (snooze_i && snooze_exhausted) ||
                (!snooze_i && tick && (ring_cnt_d == 6'(RING_SECS)))) begin
              state_q      <= S_ARMED;
              alarm_q      <= 1'b0;
              armed_q      <= 1'b1;
              snooze_cnt_q <= 3'd0;
              tgt_h_q      <= al_h_q;
              tgt_m_q      <= al_m_q;
            end else if (snooze_i) begin
              state_q      <= S_SNOOZE;
              alarm_q      <= 1'b0;
              armed_q      <= 1'b1;
              snooze_cnt_q <= snooze_cnt_q + 3'd1;
              tgt_h_q      <= snz_h_d;
              tgt_m_q      <= snz_m_d;
            end else if (tick) begin
              ring_cnt_q <= ring_cnt_d;
            end
          end
          default: begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign alarm_o      = alarm_q;
  assign armed_o      = armed_q;
  assign snooze_cnt_o = snooze_cnt_q;
  assign set_err_o    = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: directed scenarios followed by randomized traffic.
// Every cycle the DUT outputs are compared with a minute-of-day reference model.
// Ports: drives all alarm_ctrl inputs, observes alarm/armed/snooze count/set error.
module tb_alarm_ctrl;
  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RING  = 2;
  localparam int M_SNZ   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] t_sec, t_min, t_hour;
  logic       en, set, snz, stp;
  logic [5:0] ah, am;
  logic       alarm_o, armed_o, set_err_o;
  logic [2:0] snooze_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: times kept as minute-of-day integers.
  int m_mode, m_alarm_mod, m_tgt_mod, m_prev_sec, m_ring_ticks, m_snoozes;
  bit m_prev_at, m_alarm, m_armed, m_err;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .RING_SECS (RING_SECS),
    .SNOOZE_MIN(SNOOZE_MIN),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .sec_i       (t_sec),
    .min_i       (t_min),
    .hour_i      (t_hour),
    .enable_i    (en),
    .set_i       (set),
    .alarm_hour_i(ah),
    .alarm_min_i (am),
    .snooze_i    (snz),
    .stop_i      (stp),
    .alarm_o     (alarm_o),
    .armed_o     (armed_o),
    .snooze_cnt_o(snooze_cnt_o),
    .set_err_o   (set_err_o)
  );

  task automatic model_reset();
    m_mode = M_IDLE; m_alarm_mod = 0; m_tgt_mod = 0; m_prev_sec = 0;
    m_ring_ticks = 0; m_snoozes = 0; m_prev_at = 0;
    m_alarm = 0; m_armed = 0; m_err = 0;
  endtask

  task automatic model_rearm();
    m_mode = M_ARMED; m_snoozes = 0; m_tgt_mod = m_alarm_mod;
  endtask

  task automatic model_step();
    int now_mod;
    bit at, trig, tick;
    now_mod = int'(t_hour) * 60 + int'(t_min);
    at   = (now_mod == m_tgt_mod) && (t_sec == 6'd0);
    trig = at && !m_prev_at;
    tick = (int'(t_sec) != m_prev_sec);
    m_prev_at  = at;
    m_prev_sec = int'(t_sec);
    m_err = 0;
    if (set && m_mode != M_RING) begin
      if (ah <= 6'd23 && am <= 6'd59) begin
        m_alarm_mod = int'(ah) * 60 + int'(am);
        m_tgt_mod   = m_alarm_mod;
        m_snoozes   = 0;
        if (m_mode == M_SNZ) m_mode = M_ARMED;
      end else begin
        m_err = 1;
      end
    end
    if (!en) begin
      m_mode = M_IDLE; m_snoozes = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARMED; m_tgt_mod = m_alarm_mod;
    end else if (m_mode != M_RING) begin
      if (trig) begin m_mode = M_RING; m_ring_ticks = 0; end
    end else if (stp || snz) begin
      if (!stp && m_snoozes < MAX_SNOOZE) begin
        m_snoozes++;
        m_tgt_mod = (now_mod + SNOOZE_MIN) % 1440;
        m_mode = M_SNZ;
      end else begin
        model_rearm();
      end
    end else if (tick) begin
      m_ring_ticks++;
      if (m_ring_ticks >= RING_SECS) model_rearm();
    end
    m_alarm = (m_mode == M_RING);
    m_armed = (m_mode == M_ARMED) || (m_mode == M_SNZ);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".alarm"},  8'(alarm_o),      8'(m_alarm));
    chk({tag, ".armed"},  8'(armed_o),      8'(m_armed));
    chk({tag, ".snzcnt"}, 8'(snooze_cnt_o), 8'(m_snoozes));
    chk({tag, ".seterr"}, 8'(set_err_o),    8'(m_err));
  endtask

  // One clock: inputs already driven; model follows the edge; sample #1 later.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    set = 1'b0; snz = 1'b0; stp = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_hour = 6'(h); t_min = 6'(m); t_sec = 6'(s);
  endtask

  task automatic adv_sec();
    if (t_sec == 6'd59) begin
      t_sec = 6'd0;
      if (t_min == 6'd59) begin
        t_min  = 6'd0;
        t_hour = (t_hour == 6'd23) ? 6'd0 : t_hour + 6'd1;
      end else begin
        t_min = t_min + 6'd1;
      end
    end else begin
      t_sec = t_sec + 6'd1;
    end
  endtask

  task automatic program_alarm(input int h, input int m);
    ah = 6'(h); am = 6'(m); set = 1'b1;
  endtask

  initial begin
    int r, tm;
    rst = 1'b1; en = 1'b0; set = 1'b0; snz = 1'b0; stp = 1'b0;
    ah = 6'd0; am = 6'd0;
    set_time(0, 0, 0);
    model_reset();
    #12;
    check_outputs("reset");
    #1 rst = 1'b0;

    // Alarm 00:00 after reset.
    set_time(23, 59, 58); en = 1'b1;
    step("arm");
    chk("arm_armed", 8'(armed_o), 8'd1);
    set_time(23, 59, 59); step("pre_midnight");
    set_time(0, 0, 0);    step("midnight");
    chk("midnight_ring", 8'(alarm_o), 8'd1);
    chk("midnight_armed_low", 8'(armed_o), 8'd0);
    stp = 1'b1; step("stop_midnight");
    step("hold1"); step("hold2");
    chk("no_retrigger_hold", 8'(alarm_o), 8'd0);

    // Alarm 07:30 with stop while held at the target.
    program_alarm(7, 30); step("set_0730");
    set_time(7, 29, 59); step("pre_0730");
    set_time(7, 30, 0);  step("at_0730");
    chk("ring_0730", 8'(alarm_o), 8'd1);
    stp = 1'b1; step("stop_0730");
    step("hold_0730_a"); step("hold_0730_b"); step("hold_0730_c");
    chk("no_retrigger_0730", 8'(alarm_o), 8'd0);

    // Out-of-range set: error pulse, alarm stays 07:30.
    program_alarm(24, 0); step("bad_set");
    chk("set_err_pulse", 8'(set_err_o), 8'd1);
    step("after_bad_set");
    chk("set_err_single", 8'(set_err_o), 8'd0);
    set_time(7, 29, 59); step("pre_0730_again");
    set_time(7, 30, 0);  step("at_0730_again");
    chk("alarm_kept_0730", 8'(alarm_o), 8'd1);
    stp = 1'b1; step("stop_0730_again");

    // Snooze across midnight, then exhaust the snooze budget.
    program_alarm(23, 58); step("set_2358");
    set_time(23, 57, 59); step("pre_2358");
    set_time(23, 58, 0);  step("at_2358");
    chk("ring_2358", 8'(alarm_o), 8'd1);
    for (int k = 0; k < MAX_SNOOZE; k++) begin
      snz = 1'b1; step("snooze");
      chk("snooze_count", 8'(snooze_cnt_o), 8'(k + 1));
      chk("snooze_armed", 8'(armed_o), 8'd1);
      tm = (23 * 60 + 58 + (k + 1) * SNOOZE_MIN) % 1440;
      set_time(((tm + 1439) % 1440) / 60, ((tm + 1439) % 1440) % 60, 59);
      step("pre_snooze_tgt");
      set_time(tm / 60, tm % 60, 0); step("at_snooze_tgt");
      chk("snooze_reringing", 8'(alarm_o), 8'd1);
    end
    snz = 1'b1; step("snooze_exhausted");
    chk("exhausted_alarm", 8'(alarm_o), 8'd0);
    chk("exhausted_armed", 8'(armed_o), 8'd1);
    chk("exhausted_cnt", 8'(snooze_cnt_o), 8'd0);

    // Auto-timeout after RING_SECS ticks.
    program_alarm(10, 0); step("set_1000");
    set_time(9, 59, 59); step("pre_1000");
    set_time(10, 0, 0);  step("at_1000");
    for (int k = 0; k < RING_SECS; k++) begin
      adv_sec(); step("ringing");
      if (k == RING_SECS - 2) chk("still_ringing", 8'(alarm_o), 8'd1);
    end
    chk("timeout_alarm", 8'(alarm_o), 8'd0);
    chk("timeout_armed", 8'(armed_o), 8'd1);

    // Stop and snooze together: stop wins.
    program_alarm(11, 0); step("set_1100");
    set_time(10, 59, 59); step("pre_1100");
    set_time(11, 0, 0);   step("at_1100");
    snz = 1'b1; step("snooze_1100");
    set_time(11, 4, 59); step("pre_1105");
    set_time(11, 5, 0);  step("at_1105");
    stp = 1'b1; snz = 1'b1; step("stop_and_snooze");
    chk("stop_wins_cnt", 8'(snooze_cnt_o), 8'd0);
    chk("stop_wins_armed", 8'(armed_o), 8'd1);

    // Asynchronous reset between edges while ringing.
    program_alarm(12, 0); step("set_1200");
    set_time(11, 59, 59); step("pre_1200");
    set_time(12, 0, 0);   step("at_1200");
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("async_reset_alarm", 8'(alarm_o), 8'd0);
    check_outputs("mid_reset");
    #2 rst = 1'b0;

    // Enable dropped while snoozing.
    set_time(23, 59, 59); step("rearm_after_reset");
    set_time(0, 0, 0);    step("ring_after_reset");
    chk("alarm_lost_to_0000", 8'(alarm_o), 8'd1);
    snz = 1'b1; step("snooze_then_disable");
    en = 1'b0; step("disable");
    chk("disable_armed", 8'(armed_o), 8'd0);
    chk("disable_cnt", 8'(snooze_cnt_o), 8'd0);

    // Randomized traffic around the current target.
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        adv_sec();
      end else if (r < 13) begin
        // hold time
      end else if (r < 16) begin
        tm = (m_tgt_mod + 1439) % 1440;
        set_time(tm / 60, tm % 60, 59);
      end else if (r < 17) begin
        set_time(m_tgt_mod / 60, m_tgt_mod % 60, 0);
      end else begin
        set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end
      en  = ($urandom_range(0, 49) != 0);
      snz = ($urandom_range(0, 24) == 0);
      stp = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) begin
        program_alarm($urandom_range(0, 31), $urandom_range(0, 63));
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
